// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous IMEM with next_pc
// and loads the IF/ID register, honouring redirects, stalls and halt/resume.
module if_stage #(
  parameter int unsigned         PC_W     = 16,
  parameter int unsigned         INSTR_W  = 16,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               vld_q, vld_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = 1'b0;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    case (state_q)
      // One idle cycle after reset so IMEM output lines up with pc.
      S_BOOT: state_d = halt_req ? S_HALT : S_RUN;
      S_RUN: begin
        if (br_taken) begin
          vld_d = 1'b0;
        end else if (stall) begin
          vld_d = vld_q;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else begin
          vld_d   = 1'b1;
          ifpc_d  = pc_q;
          instr_d = imem_rdata;
          pc_d    = pc_q + 1'b1;
        end
      end
      S_HALT: if (resume && !halt_req) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    // Redirect wins in every state; wrong-path fetch is dropped above.
    if (br_taken) pc_d = br_target;
  end

  // IMEM sees next_pc so that imem_rdata always corresponds to pc.
  assign imem_addr = sys_rst ? RESET_PC : pc_d;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      ifpc_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_valid = vld_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_instr = instr_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; IMEM holds 0xA000+addr, expectations go through a queue.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        sys_rst, stall, br_taken, halt_req, resume;
  logic [15:0] br_target, imem_addr, imem_rdata, pc, if_id_pc, if_id_instr;
  logic        if_id_valid, halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic        vld;
    logic [15:0] ifpc;
    logic        hlt;
  } exp_t;
  exp_t q[$];

  if_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .sys_rst(sys_rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .halt_req(halt_req), .resume(resume),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 16'hA000 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_vld"}, if_id_valid, 1'b0);
    chk({tag, "_ifpc"}, if_id_pc, 16'h0000);
    chk({tag, "_instr"}, if_id_instr, 16'h0000);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then compare.
  task automatic step(input logic b, input logic [15:0] t, input logic s,
                      input logic h, input logic r,
                      input logic [15:0] epc, input logic ev,
                      input logic [15:0] eifpc, input logic eh);
    exp_t e, g;
    logic [15:0] ei;
    br_taken = b; br_target = t; stall = s; halt_req = h; resume = r;
    e.pc = epc; e.vld = ev; e.ifpc = eifpc; e.hlt = eh;
    q.push_back(e);
    @(posedge clk); #1;
    g = q.pop_front();
    chk("pc", pc, g.pc);
    chk("valid", if_id_valid, g.vld);
    if (g.vld) begin
      ei = 16'hA000 + g.ifpc;
      chk("if_id_pc", if_id_pc, g.ifpc);
      chk("if_id_instr", if_id_instr, ei);
    end
    chk("halted", halted, g.hlt);
  endtask

  initial begin
    sys_rst = 1'b1; stall = 0; br_taken = 0; br_target = 0; halt_req = 0; resume = 0;
    repeat (5) @(posedge clk);
    #1 check_reset_vals("rst");
    sys_rst = 1'b0;
    // boot then steady fetch
    step(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0001, 1, 16'h0000, 0);
    step(0, 0, 0, 0, 0, 16'h0002, 1, 16'h0001, 0);
    step(0, 0, 0, 0, 0, 16'h0003, 1, 16'h0002, 0);
    // redirect from pc=3 to 0x10: one bubble, 0x0003 never valid
    step(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0011, 1, 16'h0010, 0);
    step(1, 16'h0004, 0, 0, 0, 16'h0004, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0005, 1, 16'h0004, 0);
    // stall two cycles at pc=5
    step(0, 0, 1, 0, 0, 16'h0005, 1, 16'h0004, 0);
    step(0, 0, 1, 0, 0, 16'h0005, 1, 16'h0004, 0);
    step(0, 0, 0, 0, 0, 16'h0006, 1, 16'h0005, 0);
    step(0, 0, 0, 0, 0, 16'h0007, 1, 16'h0006, 0);
    // branch overrides stall
    step(1, 16'h0040, 1, 0, 0, 16'h0040, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0041, 1, 16'h0040, 0);
    // wrap at top of address space
    step(1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0);
    step(0, 0, 0, 0, 0, 16'h0001, 1, 16'h0000, 0);
    // halt at pc=8; held off by stall first
    step(1, 16'h0008, 0, 0, 0, 16'h0008, 0, 0, 0);
    step(0, 0, 1, 1, 0, 16'h0008, 0, 0, 0);
    step(0, 0, 0, 1, 0, 16'h0008, 0, 0, 1);
    step(0, 0, 1, 0, 0, 16'h0008, 0, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0008, 0, 0, 1);
    step(0, 0, 1, 0, 0, 16'h0008, 0, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0008, 0, 0, 1);
    // redirect while halted, simultaneous resume+halt stays, then resume
    step(1, 16'h0020, 0, 0, 0, 16'h0020, 0, 0, 1);
    step(0, 0, 0, 1, 1, 16'h0020, 0, 0, 1);
    step(0, 0, 0, 0, 1, 16'h0020, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0021, 1, 16'h0020, 0);
    step(0, 0, 0, 0, 0, 16'h0022, 1, 16'h0021, 0);
    // asynchronous reset mid-run takes effect without a clock edge
    br_taken = 0; stall = 0; halt_req = 0; resume = 0;
    #2 sys_rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(posedge clk); #1;
    sys_rst = 1'b0;
    // branch during boot is honoured, state goes to RUN
    step(1, 16'h0030, 0, 0, 0, 16'h0030, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0031, 1, 16'h0030, 0);
    // halt requested during boot
    sys_rst = 1'b1;
    #2 sys_rst = 1'b0;
    step(0, 0, 0, 1, 0, 16'h0000, 0, 0, 1);
    step(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0001, 1, 16'h0000, 0);
    br_taken = 0; halt_req = 0; resume = 0; stall = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
